// File: rtl/wb_uart_tx_fifo.sv
// wb_uart_tx_fifo
//   Wishbone slave (8-bit) that queues console bytes in a small FIFO and
//   shifts them out as 8N1 UART frames on uart_tx.
//
// Ports
//   clk, rst_n          system clock, async active-low reset
//   wb_adr_i            register offset, low ADDR_W bits decoded
//   wb_dat_i/wb_dat_o   write / registered read data
//   wb_cyc_i, wb_stb_i  bus cycle qualifiers
//   wb_we_i             write enable
//   wb_ack_o            single-cycle acknowledge
//   uart_tx             serial output, idle high
//   irq_empty           FIFO empty and serialiser idle (registered)
//
// Register map
//   0x0 DATA   W: push byte                R: 0
//   0x1 STATUS R: {0000, ovf, busy, empty, full}   W: bit3=1 clears ovf
//   0x2 CTRL   [0] enable (R/W), [1] flush (W, self-clearing)
//   0x3 COUNT  R: FIFO occupancy, saturating at 255
//
// Serialiser states
//   IDLE  | line high, pops the FIFO head when enabled and not empty
//   START | start bit (low) for CLK_DIV clocks
//   DATA  | 8 data bits LSB first, CLK_DIV clocks each
//   STOP  | stop bit (high) for CLK_DIV clocks

module wb_uart_tx_fifo #(
  parameter int CLK_DIV    = 234,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  output logic       uart_tx,
  output logic       irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wptr, rptr, count;
  logic            full, empty, overflow, enable;
  logic [15:0]     count_w;
  logic [7:0]      count_rd, rd_data;

  logic [ADDR_W-1:0] offset;
  logic            wb_req, wr_fire, push_req, push_ok, pop, flush, ctrl_wr, w1c_ovf;
  logic [7:0]      unused_adr;

  assign unused_adr = wb_adr_i;
  assign offset     = wb_adr_i[ADDR_W-1:0];

  assign count    = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign count_w  = 16'(count);
  assign count_rd = (count_w > 16'd255) ? 8'hFF : count_w[7:0];

  // Writes take effect in the ack cycle so each access acts exactly once.
  assign wb_req   = wb_cyc_i & wb_stb_i;
  assign wr_fire  = wb_req & wb_ack_o & wb_we_i;
  assign push_req = wr_fire & (offset == ADDR_W'(0));
  assign w1c_ovf  = wr_fire & (offset == ADDR_W'(1)) & wb_dat_i[3];
  assign ctrl_wr  = wr_fire & (offset == ADDR_W'(2));
  assign flush    = ctrl_wr & wb_dat_i[1];

  assign pop = (state == IDLE) & enable & ~empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push_req & ~flush & (~full | pop);

  always_comb begin
    rd_data = 8'h00;
    if (!wb_we_i) begin
      if (offset == ADDR_W'(1))
        rd_data = {4'b0000, overflow, (state != IDLE), empty, full};
      else if (offset == ADDR_W'(2))
        rd_data = {7'b0000000, enable};
      else if (offset == ADDR_W'(3))
        rd_data = count_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
    end else begin
      wb_ack_o <= wb_req & ~wb_ack_o;
      wb_dat_o <= (wb_req & ~wb_ack_o) ? rd_data : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      enable   <= 1'b1;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop)     rptr <= rptr + 1'b1;
      end
      if (push_req & ~flush & full & ~pop) overflow <= 1'b1;
      else if (w1c_ovf)                    overflow <= 1'b0;
      if (ctrl_wr) enable <= wb_dat_i[0];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wb_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rptr[AW-1:0]];
            baud_cnt <= BAUD_LOAD;
            uart_tx  <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == '0) begin
            uart_tx  <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            bit_cnt  <= '0;
            baud_cnt <= BAUD_LOAD;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_cnt == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              uart_tx <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          // The following IDLE cycle gives one idle-high clock between frames.
          if (baud_cnt == '0) state <= IDLE;
          else                baud_cnt <= baud_cnt - 1'b1;
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_empty <= 1'b1;
    else        irq_empty <= empty & (state == IDLE);
  end

endmodule

// File: doc/wb_uart_tx_fifo.md
Name: wb_uart_tx_fifo

Overview:
Wishbone slave that buffers bytes written by the SPI/Wishbone master and serialises them as 8N1 UART on a single TX pin. It hangs off a free decoder slave port on the 8-bit Wishbone fabric, as a peer of the RGB LED, video and USB slaves, and runs on the 27 MHz system clock. It is a dedicated, flow-controlled debug/console output, replacing ad-hoc UART debug inside the bridge.

Parameters:
CLK_DIV, 234, system clocks per UART bit (27 MHz / 115200 ≈ 234); legal range 2..65535
FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256
ADDR_W, 4, number of wb_adr_i LSBs decoded

Ports:
clk  in  1  system clock (27 MHz)
rst_n  in  1  asynchronous active-low reset
wb_adr_i  in  8  Wishbone address; only [ADDR_W-1:0] decoded
wb_dat_i  in  8  write data
wb_dat_o  out  8  read data
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_ack_o  out  1  acknowledge
uart_tx  out  1  serial output, idle high
irq_empty  out  1  high while FIFO empty and serialiser idle

Behaviour:
- Reset (async assert, sync release): uart_tx=1, wb_ack_o=0, wb_dat_o=0, irq_empty=1; FIFO empty; serialiser in IDLE; CTRL.enable=1; overflow=0.
- Wishbone: wb_ack_o <= cyc & stb & ~wb_ack_o. Gives a one-cycle ack, one clock after the strobe is sampled. Holding stb produces ack every other cycle.
- Side effects (push, W1C, flush) happen only in the ack cycle, exactly once per access.
- wb_dat_o is registered alongside ack. Unmapped addresses read 0 and ignore writes.
- Register map (offset = adr[3:0]):
  - 0x0 DATA: write pushes wb_dat_i[7:0]. Reads return 0.
  - 0x1 STATUS: read returns [0]=full, [1]=empty, [2]=busy (serialiser not IDLE), [3]=overflow, [7:4]=0. Writing 1 to bit3 clears overflow.
  - 0x2 CTRL: [0]=enable (R/W). [1]=flush (write-only, self-clearing, reads 0).
  - 0x3 COUNT: read returns FIFO occupancy, 0..FIFO_DEPTH, saturating at 255.
- FIFO: circular, with read/write pointers one bit wider than log2(FIFO_DEPTH) for full/empty detection; pointers wrap naturally.
  - Push when full: data dropped, overflow set (sticky), pointers unchanged.
  - Push and pop in the same cycle: both take effect and count is unchanged. This includes the case where the FIFO is full, because the pop frees the slot in that same cycle.
  - Flush: pointers reset to empty in the ack cycle. A byte already in the serialiser completes normally. A push in the same cycle as a flush is discarded, because flush wins.
- Serialiser FSM with bit counter 0..7 and baud counter 0..CLK_DIV-1:
  - IDLE: if enable & ~empty, pop the head into the shift register and go to START. Otherwise uart_tx=1.
  - START: uart_tx=0 for CLK_DIV clocks, then go to DATA.
  - DATA: LSB first, each bit held CLK_DIV clocks; after bit 7 go to STOP.
  - STOP: uart_tx=1 for CLK_DIV clocks, then go to IDLE.
  - A frame is exactly 10*CLK_DIV clocks.
  - IDLE evaluates pop in the same cycle STOP ends? No: IDLE checks the FIFO on its own cycles, so back-to-back bytes have a gap of exactly 1 clock of idle high between frames.
- Latency: the ack cycle that pushes into an empty FIFO with enable=1 is followed by uart_tx falling 2 clocks later (push visible, then pop/START registered).
- Clearing enable mid-frame finishes the current frame and then holds in IDLE. Data is retained.
- irq_empty = empty & (state==IDLE), registered.
- Reset mid-frame: immediate return to reset state; the partial frame is truncated and uart_tx is forced high.

Test Plan:
- Reset values: assert rst_n=0 mid-simulation -> uart_tx=1, irq_empty=1. After release, STATUS reads 0x02 and COUNT reads 0.
- Single byte, CLK_DIV=4: write DATA=0xA5 -> uart_tx falls 2 clocks after ack. Bits 1,0,1,0,0,1,0,1 (LSB first) follow, 4 clocks each, then stop high. Total frame 40 clocks. irq_empty returns to 1 after stop.
- Back-to-back, CLK_DIV=4: write 0x55 then 0x0F -> two 40-clock frames separated by exactly 1 idle-high clock. A decoded receiver model gets 0x55 then 0x0F in order.
- Full/overflow, CTRL.enable=0: write 17 bytes (0x00..0x10) -> COUNT=16, STATUS=0x09. Write STATUS=0x08 -> STATUS=0x01. Set enable=1 -> bytes 0x00..0x0F are transmitted and 0x10 never appears.
- Flush mid-frame: queue 4 bytes, flush during the first frame -> the first byte completes, no further frames, COUNT=0, STATUS=0x02 after stop.
- Wishbone protocol: hold cyc=stb=1 with we=1 to DATA for 6 clocks -> exactly 3 ack pulses and 3 bytes pushed. Read of offset 0x7 returns 0x00 with ack.
